// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   imem_state_e : load FSM states (IDLE = nothing loaded, LOAD, READY)
//   imem_fault_e : fetch fault codes driven on fetch_fault
//   word_idx_w() : width of a word index for a given DEPTH
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } imem_state_e;

   typedef enum logic [2:0] {
      FLT_OK       = 3'd0,
      FLT_UNLOADED = 3'd1,
      FLT_MISALIGN = 3'd2,
      FLT_RANGE    = 3'd3,
      FLT_PARITY   = 3'd4
   } imem_fault_e;

   function automatic int word_idx_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// Load controller: program-load FSM and the load_count word counter.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   load_start          - begin a new load at word 0 (ignored while loading)
//   load_valid/last     - stream handshake qualifiers
//   load_ready          - high only while loading
//   load_count          - number of words in the current program
//   state               - current FSM state (for fetch fault decode)
//   wr_en / wr_idx      - array write strobe and word index
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int IW    = word_idx_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic          load_last,
   output logic          load_ready,
   output logic [CW-1:0] load_count,
   output imem_state_e   state,
   output logic          wr_en,
   output logic [IW-1:0] wr_idx
);

   imem_state_e   state_q, state_d;
   logic [CW-1:0] count_q;
   logic          hs;
   logic          last_slot;

   assign load_ready = (state_q == ST_LOAD);
   assign hs         = load_valid & load_ready;
   // The word being written fills the array; no room for more.
   assign last_slot  = (count_q == CW'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_READY: if (load_start) state_d = ST_LOAD;
         ST_LOAD:           if (hs && (load_last || last_slot)) state_d = ST_READY;
         default:           state_d = ST_IDLE;
      endcase
   end

   // Clear on an accepted load_start; load_start inside LOAD does nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              count_q <= '0;
      else if (state_q != ST_LOAD && load_start) count_q <= '0;
      else if (hs)                             count_q <= count_q + 1'b1;
   end

   assign load_count = count_q;
   assign state      = state_q;
   assign wr_en      = hs;
   assign wr_idx     = count_q[IW-1:0];

endmodule

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory for the MIPS + quantum-coprocessor core.
// A program streams in via load_*; fetches are served one cycle after
// acceptance with a fault code. Faulting accesses return NOP_WORD.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   load_start/valid/data/last - program load stream; load_ready, load_count out
//   fetch_req, fetch_pc        - fetch request (byte PC); fetch_ready out
//   fetch_valid/instr/fault    - registered fetch response
// Build option: IMEM_PARITY_EN adds an even-parity bit per word, checked on
// every read (fault 4). Without it no parity is stored and fault 4 never occurs.
module instr_mem_loadable
   import imem_pkg::*;
#(
   parameter int              DATA_W   = 32,
   parameter int              ADDR_W   = 32,
   parameter int              DEPTH    = 64,
   parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000,
   localparam int             CW       = $clog2(DEPTH) + 1,
   localparam int             IW       = word_idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic [CW-1:0]     load_count,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_instr,
   output logic [2:0]        fetch_fault
);

   imem_state_e     state;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;

   imem_load_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_count (load_count),
      .state      (state),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx)
   );

   // Storage (not reset: only words below load_count are ever served)
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= load_data;
   end

`ifdef IMEM_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_idx] <= ^load_data;
   end
`endif

   // Fetch decode: sampled in the accepting cycle, so a fetch coinciding
   // with load_start sees the old contents and state.
   logic [ADDR_W-3:0] widx;
   logic [IW-1:0]     ridx;
   logic              in_range;
   logic              accept;
   logic [DATA_W-1:0] rdata;
   imem_fault_e       flt;
   logic [DATA_W-1:0] instr_d;

   assign fetch_ready = (state != ST_LOAD);
   assign accept      = fetch_req & fetch_ready;
   assign widx        = fetch_pc[ADDR_W-1:2];
   assign ridx        = widx[IW-1:0];
   assign in_range    = (widx < (ADDR_W-2)'(load_count));
   assign rdata       = mem[ridx];

   always_comb begin
      flt = FLT_OK;
      if (state == ST_IDLE)          flt = FLT_UNLOADED;
      else if (fetch_pc[1:0] != 2'b0) flt = FLT_MISALIGN;
      else if (!in_range)            flt = FLT_RANGE;
`ifdef IMEM_PARITY_EN
      else if ((^rdata) != par_mem[ridx]) flt = FLT_PARITY;
`endif
      instr_d = (flt == FLT_OK) ? rdata : NOP_WORD;
   end

   // Response stage: valid for exactly one cycle per accepted request;
   // instr/fault hold their last value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid <= 1'b0;
         fetch_instr <= NOP_WORD;
         fetch_fault <= FLT_OK;
      end else begin
         fetch_valid <= accept;
         if (accept) begin
            fetch_instr <= instr_d;
            fetch_fault <= flt;
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a reference model predicts each
// fetch response when the request is driven; the monitor compares on the
// falling edge after the DUT raises fetch_valid.
module tb_instr_mem_loadable;

   localparam int DEPTH = 64;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start, load_valid, load_last;
   logic [31:0] load_data;
   logic        load_ready;
   logic [6:0]  load_count;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_ready, fetch_valid;
   logic [31:0] fetch_instr;
   logic [2:0]  fetch_fault;

   instr_mem_loadable #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] instr; logic [2:0] fault; string tag; } resp_t;
   resp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model
   int          m_state = 0;    // 0 idle, 1 load, 2 ready
   int          m_cnt   = 0;
   logic [31:0] m_mem [DEPTH];
   bit          m_bad [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic resp_t predict(input logic [31:0] pc, input string tag);
      resp_t r;
      int idx;
      idx = int'(pc >> 2);
      r.tag = tag;
      r.instr = NOP;
      if (m_state == 0)         r.fault = 3'd1;
      else if (pc[1:0] != 2'b0) r.fault = 3'd2;
      else if (idx >= m_cnt)    r.fault = 3'd3;
      else if (m_bad[idx])      r.fault = 3'd4;
      else begin
         r.fault = 3'd0;
         r.instr = m_mem[idx];
      end
      return r;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (fetch_valid === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_valid", 32'(fetch_valid), 32'd0);
         else begin
            resp_t r;
            r = sb.pop_front();
            chk({r.tag, "_instr"}, fetch_instr, r.instr);
            chk({r.tag, "_fault"}, 32'(fetch_fault), 32'(r.fault));
         end
      end
   end

   // Drive one request for the coming edge; caller ends the burst with fetch_end.
   task automatic fetch1(input logic [31:0] pc, input string tag);
      @(negedge clk);
      fetch_req = 1'b1;
      fetch_pc  = pc;
      chk({tag, "_ready"}, 32'(fetch_ready), 32'd1);
      sb.push_back(predict(pc, tag));
   endtask

   task automatic fetch_end();
      @(negedge clk);
      fetch_req = 1'b0;
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1;
      m_state = 1;
      m_cnt   = 0;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] d, input bit last);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      m_mem[m_cnt] = d;
      m_bad[m_cnt] = 1'b0;
      m_cnt++;
      if (last || m_cnt == DEPTH) m_state = 2;
   endtask

   task automatic load_end();
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      logic [31:0] prog [4];
      prog[0] = 32'h2008_0005; prog[1] = 32'h4802_0001;
      prog[2] = 32'h4822_0004; prog[3] = 32'h0800_0001;
      for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;

      rst_n = 1'b0; load_start = 0; load_valid = 0; load_last = 0;
      load_data = '0; fetch_req = 0; fetch_pc = '0;
      repeat (3) @(negedge clk);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_fetch_instr", fetch_instr, NOP);
      chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      chk("rst_load_ready", 32'(load_ready), 32'd0);
      chk("rst_load_count", 32'(load_count), 32'd0);
      rst_n = 1'b1;

      // Unloaded fetch
      fetch1(32'h0, "unloaded_pc0");
      fetch_end();

      // Four-word program
      start_load();
      chk("load_ready_in_load", 32'(load_ready), 32'd1);
      chk("fetch_ready_in_load", 32'(fetch_ready), 32'd0);
      for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
      load_end();
      chk("count_after_4", 32'(load_count), 32'd4);
      chk("load_ready_after_last", 32'(load_ready), 32'd0);

      fetch1(32'h4,  "pc04");
      fetch1(32'h10, "range_pc10");
      fetch1(32'h6,  "misalign_pc06");
      fetch1(32'hC,  "pc0c");
      fetch1(32'h0,  "pc00");
      fetch_end();

`ifdef IMEM_PARITY_EN
      dut.mem[2] = dut.mem[2] ^ 32'h1;
      m_bad[2] = 1'b1;
      fetch1(32'h8, "parity_pc08");
      fetch1(32'h4, "parity_clean_pc04");
      fetch_end();
`endif

      // load_start together with an accepted fetch: old contents served
      @(negedge clk);
      fetch_req = 1'b1; fetch_pc = 32'h4; load_start = 1'b1;
      chk("coinc_ready", 32'(fetch_ready), 32'd1);
      sb.push_back(predict(32'h4, "coinc_pc04"));
      m_state = 1; m_cnt = 0;
      @(negedge clk);
      fetch_req = 1'b0; load_start = 1'b0;
      chk("coinc_count_clr", 32'(load_count), 32'd0);

      // Full-depth load without load_last; a mid-load load_start is ignored
      for (int i = 0; i < DEPTH; i++) begin
         load_word(32'hA000_0000 + 32'(i * 3), 1'b0);
         load_start = (i == 10);
      end
      load_end();
      load_start = 1'b0;
      chk("count_full", 32'(load_count), 32'd64);
      chk("ready_after_full", 32'(fetch_ready), 32'd1);
      fetch1(32'hFC,  "full_pcfc");
      fetch1(32'h100, "full_range_pc100");
      fetch1(32'h28,  "full_pc28");
      fetch_end();

      // Reset in the middle of a load
      start_load();
      load_word(32'h1111_1111, 1'b0);
      load_word(32'h2222_2222, 1'b0);
      @(negedge clk);
      load_valid = 1'b0;
      rst_n = 1'b0;
      m_state = 0; m_cnt = 0;
      #2;
      chk("midrst_count", 32'(load_count), 32'd0);
      chk("midrst_load_ready", 32'(load_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fetch1(32'h0, "midrst_pc00");
      fetch_end();

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
